// File: rtl/wallace_mac_pkg.sv
// Shared types and defaults for the Wallace-multiplier product accumulator.
// Build option WALLACE_MAC_SAT_EN selects saturating accumulation.
package wallace_mac_pkg;

  localparam int unsigned PROD_W    = 8;
  localparam int unsigned ACC_W_DEF = 16;
  localparam int unsigned CNT_W_DEF = 8;

  typedef enum logic {
    ACCUM = 1'b0,
    DRAIN = 1'b1
  } state_t;

endpackage

// File: rtl/wallace_mac_add.sv
// Combinational accumulator adder: ACC_W-bit sum plus 8-bit product, with carry-out.
// Build option WALLACE_MAC_SAT_EN clamps the sum to all-ones on carry-out.
module wallace_mac_add
  import wallace_mac_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0]  a,
  input  logic [PROD_W-1:0] b,
  output logic [ACC_W-1:0]  sum,
  output logic              carry
);

  logic [ACC_W:0] full;

  always_comb begin
    full  = {1'b0, a} + {{(ACC_W + 1 - PROD_W){1'b0}}, b};
    carry = full[ACC_W];
`ifdef WALLACE_MAC_SAT_EN
    // Once clamped, any further add either carries again or adds zero, so the clamp sticks.
    sum   = carry ? '1 : full[ACC_W-1:0];
`else
    sum   = full[ACC_W-1:0];
`endif
  end

endmodule

// File: rtl/wallace_mac_acc.sv
// Frame accumulator for 8-bit multiplier products with valid/ready on both sides.
// Build option WALLACE_MAC_SAT_EN (via wallace_mac_add) saturates instead of wrapping.
module wallace_mac_acc
  import wallace_mac_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prod_valid,
  input  logic [PROD_W-1:0] prod,
  input  logic              prod_last,
  output logic              prod_ready,
  output logic              acc_valid,
  output logic [ACC_W-1:0]  acc_data,
  output logic [CNT_W-1:0]  acc_cnt,
  output logic              acc_ovf,
  input  logic              acc_ready
);

  if (ACC_W < PROD_W) begin : g_bad_acc_w
    $error("wallace_mac_acc: ACC_W must be >= 8");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("wallace_mac_acc: CNT_W must be >= 1");
  end

  state_t           state, state_next;
  logic [ACC_W-1:0] sum, sum_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             ovf, ovf_next;
  logic             carry;
  logic             beat;

  wallace_mac_add #(.ACC_W(ACC_W)) u_add (
    .a    (sum),
    .b    (prod),
    .sum  (sum_next),
    .carry(carry)
  );

  always_comb begin
    state_next = state;
    prod_ready = 1'b0;
    acc_valid  = 1'b0;
    case (state)
      ACCUM: begin
        prod_ready = 1'b1;
        if (prod_valid && prod_last) state_next = DRAIN;
      end
      DRAIN: begin
        acc_valid = 1'b1;
        if (acc_ready) state_next = ACCUM;
      end
      default: state_next = ACCUM;
    endcase
  end

  // prod only reaches state through beat, so X on an idle bus is never captured.
  assign beat     = prod_valid && prod_ready;
  assign cnt_next = (&cnt) ? cnt : cnt + 1'b1;
  assign ovf_next = ovf | carry;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ACCUM;
      sum      <= '0;
      cnt      <= '0;
      ovf      <= 1'b0;
      acc_data <= '0;
      acc_cnt  <= '0;
      acc_ovf  <= 1'b0;
    end else begin
      state <= state_next;
      if (beat) begin
        if (prod_last) begin
          acc_data <= sum_next;
          acc_cnt  <= cnt_next;
          acc_ovf  <= ovf_next;
          sum      <= '0;
          cnt      <= '0;
          ovf      <= 1'b0;
        end else begin
          sum <= sum_next;
          cnt <= cnt_next;
          ovf <= ovf_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_wallace_mac_acc.sv
// Self-checking bench: a default-width and a narrow (ACC_W=10, CNT_W=2) instance share stimulus.
module tb_wallace_mac_acc;

  logic       clk = 1'b0;
  logic       rst;
  logic       prod_valid;
  logic [7:0] prod;
  logic       prod_last;
  logic       acc_ready;

  logic        w_prod_ready, w_acc_valid, w_acc_ovf;
  logic [15:0] w_acc_data;
  logic [7:0]  w_acc_cnt;
  logic        n_prod_ready, n_acc_valid, n_acc_ovf;
  logic [9:0]  n_acc_data;
  logic [1:0]  n_acc_cnt;

  int errors = 0;
  int checks = 0;
  int q[$];

  always #5 clk = ~clk;

  wallace_mac_acc dut_w (
    .clk(clk), .rst(rst), .prod_valid(prod_valid), .prod(prod), .prod_last(prod_last),
    .prod_ready(w_prod_ready), .acc_valid(w_acc_valid), .acc_data(w_acc_data),
    .acc_cnt(w_acc_cnt), .acc_ovf(w_acc_ovf), .acc_ready(acc_ready)
  );

  wallace_mac_acc #(.ACC_W(10), .CNT_W(2)) dut_n (
    .clk(clk), .rst(rst), .prod_valid(prod_valid), .prod(prod), .prod_last(prod_last),
    .prod_ready(n_prod_ready), .acc_valid(n_acc_valid), .acc_data(n_acc_data),
    .acc_cnt(n_acc_cnt), .acc_ovf(n_acc_ovf), .acc_ready(acc_ready)
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: frame total by plain arithmetic, then wrap or clamp to the width.
  function automatic longint frame_total();
    longint t = 0;
    foreach (q[i]) t += q[i];
    return t;
  endfunction

  function automatic longint exp_data(input longint total, input int w);
    longint m = (longint'(1) << w) - 1;
`ifdef WALLACE_MAC_SAT_EN
    return (total > m) ? m : total;
`else
    return total % (longint'(1) << w);
`endif
  endfunction

  function automatic longint exp_cnt(input int n, input int c);
    longint m = (longint'(1) << c) - 1;
    return (n > m) ? m : n;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_w_valid"}, w_acc_valid, 0);
    check({tag, "_n_valid"}, n_acc_valid, 0);
    check({tag, "_w_ready"}, w_prod_ready, 1);
    check({tag, "_n_ready"}, n_prod_ready, 1);
  endtask

  task automatic check_result(input string tag);
    longint t = frame_total();
    check({tag, "_w_valid"}, w_acc_valid, 1);
    check({tag, "_w_data"},  w_acc_data, exp_data(t, 16));
    check({tag, "_w_cnt"},   w_acc_cnt, exp_cnt(q.size(), 8));
    check({tag, "_w_ovf"},   w_acc_ovf, (t > 65535) ? 1 : 0);
    check({tag, "_n_valid"}, n_acc_valid, 1);
    check({tag, "_n_data"},  n_acc_data, exp_data(t, 10));
    check({tag, "_n_cnt"},   n_acc_cnt, exp_cnt(q.size(), 2));
    check({tag, "_n_ovf"},   n_acc_ovf, (t > 1023) ? 1 : 0);
    check({tag, "_w_pready"}, w_prod_ready, 0);
    check({tag, "_n_pready"}, n_prod_ready, 0);
  endtask

  // Drive q as one frame; optional idle gaps carry X data and stray prod_last.
  task automatic send(input bit gaps, input bit with_last);
    for (int i = 0; i < q.size(); i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          prod_valid = 1'b0;
          prod       = 'x;
          prod_last  = 1'($urandom);
          @(posedge clk); #1;
        end
      end
      check("beat_w_ready", w_prod_ready, 1);
      prod_valid = 1'b1;
      prod       = 8'(q[i]);
      prod_last  = with_last && (i == q.size() - 1);
      @(posedge clk); #1;
    end
    prod_valid = 1'b0;
    prod_last  = 1'b0;
    prod       = 'x;
  endtask

  // Hold the result for some cycles while upstream keeps offering beats, then release.
  task automatic drain(input string tag, input int hold);
    for (int k = 0; k < hold; k++) begin
      prod_valid = 1'b1;
      prod       = 8'($urandom);
      prod_last  = 1'($urandom);
      @(posedge clk); #1;
      check_result({tag, "_hold"});
    end
    prod_valid = 1'b0;
    prod_last  = 1'b0;
    acc_ready  = 1'b1;
    @(posedge clk); #1;
    check_idle({tag, "_rel"});
  endtask

  task automatic frame(input string tag, input bit gaps, input int hold);
    acc_ready = (hold == 0);
    send(gaps, 1'b1);
    check_result(tag);
    drain(tag, hold);
  endtask

  initial begin
    rst        = 1'b1;
    prod_valid = 1'b0;
    prod       = '0;
    prod_last  = 1'b0;
    acc_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    check("reset_w_data", w_acc_data, 0);
    check("reset_w_cnt",  w_acc_cnt, 0);
    check("reset_w_ovf",  w_acc_ovf, 0);
    rst = 1'b0;

    q = '{225, 225, 225};
    frame("three_225", 1'b0, 0);

    q = '{225, 225, 225, 225, 225};
    frame("five_225", 1'b0, 0);

    q = '{0};
    frame("single_zero", 1'b0, 0);

    q = '{17, 3, 250};
    frame("pending", 1'b0, 5);
    q = '{9, 4};
    frame("after_pending", 1'b0, 0);

    q = '{1, 1, 1, 1, 1};
    frame("cnt_sat", 1'b0, 0);

    // Reset mid-frame: partial sum and prior result vanish without a clock edge.
    q = '{25, 25};
    send(1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check_idle("rst_mid");
    check("rst_mid_w_data", w_acc_data, 0);
    check("rst_mid_n_cnt",  n_acc_cnt, 0);
    @(posedge clk); #1 rst = 1'b0;
    q = '{7};
    frame("after_rst", 1'b0, 0);

    q = '{200, 100};
    acc_ready = 1'b0;
    send(1'b0, 1'b1);
    check_result("pre_rst_drain");
    #2 rst = 1'b1;
    #1;
    check_idle("rst_drain");
    check("rst_drain_w_data", w_acc_data, 0);
    @(posedge clk); #1 rst = 1'b0;
    acc_ready = 1'b1;

    for (int f = 0; f < 12; f++) begin
      int n = $urandom_range(1, 8);
      q.delete();
      for (int i = 0; i < n; i++) q.push_back($urandom_range(0, 255));
      frame("rand", 1'b1, $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
